// File: rtl/spi_ram_arbiter_if.sv
// Requester and SPI-master bus bundle for spi_ram_arbiter.
// slave = arbiter view, master = environment (requesters + SPI master) view.
interface spi_ram_arbiter_if;
  logic [1:0]  req;
  logic [1:0]  req_we;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  ack;
  logic        err;
  logic [7:0]  rdata;
  logic        m_start;
  logic [9:0]  m_data_in;
  logic [7:0]  m_data_out;
  logic        m_busy;
  logic        m_done;

  modport slave (
    input  req, req_we, req_addr, req_wdata, m_data_out, m_busy, m_done,
    output ack, err, rdata, m_start, m_data_in
  );

  modport master (
    output req, req_we, req_addr, req_wdata, m_data_out, m_busy, m_done,
    input  ack, err, rdata, m_start, m_data_in
  );
endinterface

// File: rtl/spi_ram_arbiter.sv
// Round-robin arbiter turning 2 RAM requests into two-frame SPI transactions (addr, data).
// Ack follows the last m_done by one cycle; m_busy stalls frame issue, per-frame timeout.
module spi_ram_arbiter #(
  parameter int TIMEOUT = 1000,
  parameter int TO_W    = 10
) (
  input logic              clk,
  input logic              rst_n,
  spi_ram_arbiter_if.slave bus
);

  typedef enum logic [2:0] {IDLE, ISSUE_A, WAIT_A, ISSUE_B, WAIT_B, RESP} state_t;

  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT);

  state_t          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            grant_q, grant_d;
  logic            we_q, we_d;
  logic [7:0]      wdata_q, wdata_d;
  logic [9:0]      frame_q, frame_d;
  logic            err_q, err_d;
  logic [7:0]      rdata_q, rdata_d;
  logic            pick;

  // grant_q doubles as last_grant; resetting it to 1 lets requester 0 win the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      grant_q <= 1'b1;
      we_q    <= 1'b0;
      wdata_q <= 8'h00;
      frame_q <= 10'h000;
      err_q   <= 1'b0;
      rdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      frame_q <= frame_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    frame_d = frame_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    pick    = (bus.req == 2'b11) ? ~grant_q : bus.req[1];

    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          grant_d = pick;
          we_d    = bus.req_we[pick];
          wdata_d = pick ? bus.req_wdata[15:8] : bus.req_wdata[7:0];
          frame_d = {~bus.req_we[pick], 1'b0, (pick ? bus.req_addr[15:8] : bus.req_addr[7:0])};
          state_d = ISSUE_A;
        end
      end
      ISSUE_A: begin
        if (!bus.m_busy) begin
          cnt_d   = '0;
          state_d = WAIT_A;
        end
      end
      WAIT_A: begin
        // m_done wins over a simultaneous timeout
        if (bus.m_done) begin
          frame_d = {~we_q, 1'b1, (we_q ? wdata_q : 8'h00)};
          state_d = ISSUE_B;
        end else if (cnt_q == TO_MAX) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      ISSUE_B: begin
        if (!bus.m_busy) begin
          cnt_d   = '0;
          state_d = WAIT_B;
        end
      end
      WAIT_B: begin
        if (bus.m_done) begin
          if (!we_q) rdata_d = bus.m_data_out;
          state_d = RESP;
        end else if (cnt_q == TO_MAX) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      RESP: begin
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.m_start   = ((state_q == ISSUE_A) || (state_q == ISSUE_B)) && !bus.m_busy;
  assign bus.m_data_in = frame_q;
  assign bus.ack       = (state_q == RESP) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
  assign bus.err       = err_q;
  assign bus.rdata     = rdata_q;

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Bench for spi_ram_arbiter: directed scenarios plus randomized transactions checked
// against a transaction-level model of frames, ack timing, err and rdata.
module tb_spi_ram_arbiter;
  localparam int TIMEOUT = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [7:0] model_rdata;

  spi_ram_arbiter_if bus ();

  spi_ram_arbiter #(.TIMEOUT(TIMEOUT), .TO_W(10)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One transaction from requester r; the bench plays the SPI master.
  // dly_x: cycles from m_start to m_done for frame x (0 = never answer).
  task automatic run_txn(input int r, input bit we, input logic [7:0] addr, input logic [7:0] wdata,
                         input logic [7:0] rbyte, input int dly_a, input int dly_b,
                         input int busy_first, input bit rand_busy, input bit drop_early,
                         input bit abort);
    logic [9:0] exp_fr [2];
    bit to_a, to_b, exp_err, got_ack, awaiting;
    int exp_frames, nfr, cd, last_start, last_done, exp_cyc;
    to_a       = (dly_a == 0) || (dly_a > TIMEOUT + 1);
    to_b       = (dly_b == 0) || (dly_b > TIMEOUT + 1);
    exp_err    = to_a || (!to_a && to_b);
    exp_frames = to_a ? 1 : 2;
    exp_fr[0]  = {(we ? 2'b00 : 2'b10), addr};
    exp_fr[1]  = {(we ? 2'b01 : 2'b11), (we ? wdata : 8'h00)};
    nfr = 0; cd = 0; last_start = 0; last_done = -1; got_ack = 1'b0;
    for (int cyc = 0; cyc < 200 && !got_ack; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        bus.req_we    = 2'($urandom);
        bus.req_addr  = 16'($urandom);
        bus.req_wdata = 16'($urandom);
        bus.req_we[r] = we;
        bus.req_addr[8*r +: 8]  = addr;
        bus.req_wdata[8*r +: 8] = wdata;
        bus.req    = 2'b00;
        bus.req[r] = 1'b1;
      end
      if (drop_early && nfr > 0) bus.req[r] = 1'b0;
      bus.m_busy     = rand_busy ? ($urandom_range(0, 3) == 0) : (cyc >= 1 && cyc <= busy_first);
      bus.m_done     = 1'b0;
      bus.m_data_out = 8'($urandom);
      awaiting = (nfr == 1 && dly_a == 0) || (nfr == 2 && dly_b == 0);
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          bus.m_done = 1'b1;
          last_done  = cyc;
          if (nfr == 2) bus.m_data_out = rbyte;
        end
      end else if (rand_busy && !awaiting && $urandom_range(0, 3) == 0) begin
        bus.m_done = 1'b1;  // stray pulse outside a WAIT state
      end
      #1;
      checks++;
      if ((bus.ack & (bus.ack - 2'd1)) != 2'b00) begin
        errors++; $display("FAIL ack_onehot: got %b required one-hot or zero", bus.ack);
      end
      if (bus.m_done && last_done == cyc) begin
        checks++;
        if (bus.m_data_in !== exp_fr[nfr-1]) begin
          errors++; $display("FAIL frame_hold: got %h required %h", bus.m_data_in, exp_fr[nfr-1]);
        end
      end
      if (bus.m_start) begin
        checks++;
        if (bus.m_busy) begin
          errors++; $display("FAIL start_while_busy: got m_start=1 required 0");
        end else if (nfr >= exp_frames) begin
          errors++; $display("FAIL extra_frame: got frame %0d required %0d frames", nfr + 1, exp_frames);
        end else if (bus.m_data_in !== exp_fr[nfr]) begin
          errors++; $display("FAIL frame_value: got %h required %h", bus.m_data_in, exp_fr[nfr]);
        end
        if (nfr == 0 && !rand_busy) begin
          checks++;
          if (cyc != busy_first + 1) begin
            errors++; $display("FAIL start_cycle: got %0d required %0d", cyc, busy_first + 1);
          end
        end
        cd = (nfr == 0) ? dly_a : dly_b;
        nfr++;
        last_start = cyc;
      end
      if (abort && nfr == 2 && cyc == last_start + 1) begin
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.ack !== 2'b00 || bus.err !== 1'b0 || bus.rdata !== 8'h00 ||
            bus.m_start !== 1'b0 || bus.m_data_in !== 10'h000) begin
          errors++;
          $display("FAIL reset_midop: got ack=%b err=%b rdata=%h start=%b din=%h required all zero",
                   bus.ack, bus.err, bus.rdata, bus.m_start, bus.m_data_in);
        end
        bus.req = 2'b00; bus.m_busy = 1'b0; bus.m_done = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (bus.ack !== 2'b00) begin
          errors++; $display("FAIL reset_no_ack: got %b required 00", bus.ack);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_rdata = 8'h00;
        return;
      end
      if (bus.ack != 2'b00) begin
        got_ack = 1'b1;
        if (!we && !exp_err) model_rdata = rbyte;
        exp_cyc = exp_err ? last_start + TIMEOUT + 2 : last_done + 1;
        checks += 5;
        if (bus.ack !== 2'(1 << r)) begin
          errors++; $display("FAIL ack_target: got %b required %b", bus.ack, 2'(1 << r));
        end
        if (bus.err !== exp_err) begin
          errors++; $display("FAIL err: got %b required %b", bus.err, exp_err);
        end
        if (bus.rdata !== model_rdata) begin
          errors++; $display("FAIL rdata: got %h required %h", bus.rdata, model_rdata);
        end
        if (nfr != exp_frames) begin
          errors++; $display("FAIL frame_count: got %0d required %0d", nfr, exp_frames);
        end
        if (cyc != exp_cyc) begin
          errors++; $display("FAIL ack_cycle: got %0d required %0d", cyc, exp_cyc);
        end
      end
    end
    if (!got_ack) begin
      checks++; errors++;
      $display("FAIL ack_missing: got no ack required one within 200 cycles");
    end
    @(negedge clk);
    bus.req = 2'b00; bus.m_done = 1'b0; bus.m_busy = 1'b0;
    #1;
    checks++;
    if (bus.ack !== 2'b00 || bus.err !== 1'b0) begin
      errors++; $display("FAIL after_resp: got ack=%b err=%b required 00/0", bus.ack, bus.err);
    end
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if (bus.ack !== 2'b00 || bus.err !== 1'b0 || bus.rdata !== 8'h00 ||
        bus.m_start !== 1'b0 || bus.m_data_in !== 10'h000) begin
      errors++;
      $display("FAIL reset_state: got ack=%b err=%b rdata=%h start=%b din=%h required all zero",
               bus.ack, bus.err, bus.rdata, bus.m_start, bus.m_data_in);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_write;
    run_txn(0, 1'b1, 8'h12, 8'hA5, 8'h00, 2, 3, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_read;
    run_txn(1, 1'b0, 8'h34, 8'h00, 8'h5C, 1, 2, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_timeout;
    run_txn(0, 1'b1, 8'h40, 8'h11, 8'h00, 0, 1, 0, 1'b0, 1'b0, 1'b0);
    run_txn(1, 1'b0, 8'h41, 8'h00, 8'h99, 1, 0, 0, 1'b0, 1'b0, 1'b0);
    run_txn(0, 1'b0, 8'h42, 8'h00, 8'h77, TIMEOUT + 2, 1, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_timeout_boundary;
    run_txn(1, 1'b0, 8'h55, 8'h00, 8'hC3, TIMEOUT + 1, TIMEOUT + 1, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_busy_stall;
    run_txn(0, 1'b0, 8'h77, 8'h00, 8'h3C, 1, 1, 5, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_drop_req;
    run_txn(1, 1'b1, 8'h88, 8'h5A, 8'h00, 3, 2, 0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_midop;
    run_txn(1, 1'b0, 8'h9A, 8'h00, 8'hEE, 1, 0, 0, 1'b0, 1'b0, 1'b1);
    run_txn(0, 1'b0, 8'h21, 8'h00, 8'h44, 2, 3, 0, 1'b0, 1'b0, 1'b0);
  endtask

  // Both requesters hold req continuously: service must alternate 0,1,0,1 with an idle gap.
  task automatic test_tie;
    int exp_last, acks, cd, ack_cyc, winner;
    bit seen_a;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_rdata = 8'h00;
    bus.req_we = 2'b11; bus.req_addr = 16'hB1A0; bus.req_wdata = 16'h2211;
    bus.req = 2'b11;
    exp_last = 1; acks = 0; cd = 0; ack_cyc = 0; seen_a = 1'b0;
    for (int cyc = 0; cyc < 200 && acks < 4; cyc++) begin
      @(negedge clk);
      bus.m_busy = 1'b0;
      bus.m_done = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) bus.m_done = 1'b1;
      end
      #1;
      if (bus.m_start) begin
        if (!seen_a) begin
          winner = 1 - exp_last;
          checks++;
          if (bus.m_data_in !== {2'b00, (winner == 1 ? 8'hB1 : 8'hA0)}) begin
            errors++; $display("FAIL tie_frame: got %h required %h", bus.m_data_in,
                               {2'b00, (winner == 1 ? 8'hB1 : 8'hA0)});
          end
          if (acks > 0) begin
            checks++;
            if (cyc != ack_cyc + 2) begin
              errors++; $display("FAIL idle_gap: got start at %0d required %0d", cyc, ack_cyc + 2);
            end
          end
          seen_a = 1'b1;
        end
        cd = 1;
      end
      if (bus.ack != 2'b00) begin
        winner = 1 - exp_last;
        checks++;
        if (bus.ack !== 2'(1 << winner)) begin
          errors++; $display("FAIL tie_order: got %b required %b", bus.ack, 2'(1 << winner));
        end
        exp_last = winner;
        acks++;
        ack_cyc = cyc;
        seen_a = 1'b0;
      end
    end
    @(negedge clk);
    bus.req = 2'b00; bus.m_done = 1'b0;
    checks++;
    if (acks != 4) begin
      errors++; $display("FAIL tie_count: got %0d acks required 4", acks);
    end
    @(negedge clk);
  endtask

  task automatic pick_dly(output int d);
    int p;
    p = $urandom_range(0, 9);
    if (p == 0)      d = 0;
    else if (p == 1) d = TIMEOUT + 1;
    else if (p == 2) d = TIMEOUT + 2;
    else             d = $urandom_range(1, 4);
  endtask

  task automatic test_random;
    int da, db;
    for (int i = 0; i < 16; i++) begin
      pick_dly(da);
      pick_dly(db);
      run_txn(int'($urandom_range(0, 1)), 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
              da, db, 0, 1'b1, 1'($urandom), 1'b0);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    model_rdata = 8'h00;
    rst_n = 1'b0;
    bus.req = 2'b00; bus.req_we = 2'b00; bus.req_addr = 16'h0000; bus.req_wdata = 16'h0000;
    bus.m_data_out = 8'h00; bus.m_busy = 1'b0; bus.m_done = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_tie();
    test_timeout();
    test_timeout_boundary();
    test_busy_stall();
    test_drop_req();
    test_reset_midop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
